// File: rtl/rv32i_types.sv
// Shared pipeline/memory types used by the cacheline arbiter.
package rv32i_types;

    typedef enum logic [1:0] {ARB_IDLE, ARB_I, ARB_D} arb_state_t;

    localparam int CACHELINE_W   = 256;
    localparam int LINE_OFFSET_W = 5;

endpackage

// File: rtl/cacheline_arbiter_if.sv
// I-cache, D-cache and backing-memory bundle; slave = arbiter view, master = requesters + memory.
interface cacheline_arbiter_if
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = CACHELINE_W
);
    logic [ADDR_W-1:0] i_addr;
    logic              i_read;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic [ADDR_W-1:0] d_addr;
    logic              d_read;
    logic              d_write;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  i_addr, i_read, d_addr, d_read, d_write, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_addr, mem_read, mem_write, mem_wdata
    );

    modport master (
        output i_addr, i_read, d_addr, d_read, d_write, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, mem_addr, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/cacheline_arbiter.sv
// Grants the shared line port to the I- or D-cache and routes the response back to the winner.
// Define CACHELINE_ARB_RR_EN for round-robin ties; default is fixed D-side priority.
module cacheline_arbiter
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = CACHELINE_W
)(
    input  logic                 clk,
    input  logic                 rst_n,
    cacheline_arbiter_if.slave   arb_if
);

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << LINE_OFFSET_W) - 1);

    arb_state_t        state_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_wdata_q;
    logic              mem_read_q;
    logic              mem_write_q;

    logic i_req;
    logic d_req;
    logic grant_d;

    assign i_req = arb_if.i_read;
    assign d_req = arb_if.d_read | arb_if.d_write;

`ifdef CACHELINE_ARB_RR_EN
    // last_d_q = 1 when D won the previous grant; reset value lets D win the first tie
    logic last_d_q;
    assign grant_d = d_req & (~i_req | ~last_d_q);
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
`ifdef CACHELINE_ARB_RR_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (grant_d) begin
                        state_q     <= ARB_D;
                        mem_addr_q  <= arb_if.d_addr & ~OFF_MASK;
                        mem_wdata_q <= arb_if.d_wdata;
                        // simultaneous read+write is a requester error; write wins
                        mem_write_q <= arb_if.d_write;
                        mem_read_q  <= ~arb_if.d_write;
`ifdef CACHELINE_ARB_RR_EN
                        last_d_q    <= 1'b1;
`endif
                    end else if (i_req) begin
                        state_q     <= ARB_I;
                        mem_addr_q  <= arb_if.i_addr & ~OFF_MASK;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
`ifdef CACHELINE_ARB_RR_EN
                        last_d_q    <= 1'b0;
`endif
                    end
                end
                ARB_I, ARB_D: begin
                    if (arb_if.mem_resp) begin
                        state_q     <= ARB_IDLE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ARB_IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign arb_if.mem_addr  = mem_addr_q;
    assign arb_if.mem_wdata = mem_wdata_q;
    assign arb_if.mem_read  = mem_read_q;
    assign arb_if.mem_write = mem_write_q;

    // Data may flow continuously; only the granted side ever sees resp.
    assign arb_if.i_rdata = arb_if.mem_rdata;
    assign arb_if.d_rdata = arb_if.mem_rdata;
    assign arb_if.i_resp  = (state_q == ARB_I) & arb_if.mem_resp;
    assign arb_if.d_resp  = (state_q == ARB_D) & arb_if.mem_resp;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Self-checking bench for cacheline_arbiter against a grant-order reference model.
module tb_cacheline_arbiter;
    import rv32i_types::*;

    localparam int AW = 32;
    localparam int LW = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cacheline_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();
    cacheline_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (.clk(clk), .rst_n(rst_n), .arb_if(bus));

    int errs = 0;
    int checks = 0;
    bit last_d;   // reference model: previous winner was the D-side

    function automatic bit pick_d(input bit ireq, input bit dreq);
`ifdef CACHELINE_ARB_RR_EN
        if (ireq && dreq) return !last_d;
`endif
        return dreq;
    endfunction

    function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
        return {a[AW-1:5], 5'b0};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_read = 0; bus.d_read = 0; bus.d_write = 0; bus.mem_resp = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        tick(); tick();
        rst_n = 1;
        last_d = 0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        tick();
        checks++; if (bus.mem_read !== 1'b0) begin errs++; $display("FAIL reset_mem_read got %0b want 0", bus.mem_read); end
        checks++; if (bus.mem_write !== 1'b0) begin errs++; $display("FAIL reset_mem_write got %0b want 0", bus.mem_write); end
        checks++; if (bus.mem_addr !== '0) begin errs++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== '0) begin errs++; $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata); end
        bus.mem_resp = 1; #1;
        checks++; if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin errs++; $display("FAIL reset_resp got i=%0b d=%0b want 0/0", bus.i_resp, bus.d_resp); end
        bus.mem_resp = 0;
    endtask

    task automatic test_i_read();
        logic [LW-1:0] r;
        do_reset();
        bus.i_addr = 32'h6000_0044; bus.i_read = 1;
        tick();
        for (int c = 1; c <= 3; c++) begin
            checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h6000_0040) begin errs++; $display("FAIL iread_cyc%0d got rd=%0b addr=%h want 1/60000040", c, bus.mem_read, bus.mem_addr); end
            checks++; if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin errs++; $display("FAIL iread_early_resp cyc%0d got i=%0b d=%0b want 0/0", c, bus.i_resp, bus.d_resp); end
            tick();
        end
        r = rand_line();
        bus.mem_rdata = r; bus.mem_resp = 1; #1;
        checks++; if (bus.i_resp !== 1'b1 || bus.d_resp !== 1'b0 || bus.mem_read !== 1'b1) begin errs++; $display("FAIL iread_resp got i=%0b d=%0b rd=%0b want 1/0/1", bus.i_resp, bus.d_resp, bus.mem_read); end
        checks++; if (bus.i_rdata !== r) begin errs++; $display("FAIL iread_rdata got %h want %h", bus.i_rdata, r); end
        last_d = 0;
        tick();
        bus.mem_resp = 0; bus.i_read = 0;
        checks++; if (bus.mem_read !== 1'b0) begin errs++; $display("FAIL iread_done got rd=%0b want 0", bus.mem_read); end
        tick();
    endtask

    task automatic test_d_write();
        logic [LW-1:0] w;
        int pulses = 0;
        w = {32{8'hA5}};
        bus.d_addr = 32'h0000_1F00; bus.d_wdata = w; bus.d_write = 1;
        tick();
        last_d = 1;
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin errs++; $display("FAIL dwr_strobe got wr=%0b rd=%0b want 1/0", bus.mem_write, bus.mem_read); end
        bus.d_wdata = {32{8'h5A}}; bus.d_addr = 32'h1234_5678;
        tick(); tick();
        checks++; if (bus.mem_wdata !== w || bus.mem_addr !== 32'h0000_1F00) begin errs++; $display("FAIL dwr_stable got addr=%h wdata=%h want 00001f00/%h", bus.mem_addr, bus.mem_wdata, w); end
        bus.mem_resp = 1; #1;
        pulses += int'(bus.d_resp);
        checks++; if (bus.i_resp !== 1'b0) begin errs++; $display("FAIL dwr_iresp got %0b want 0", bus.i_resp); end
        tick();
        bus.mem_resp = 0; bus.d_write = 0; #1;
        pulses += int'(bus.d_resp);
        tick();
        pulses += int'(bus.d_resp);
        checks++; if (pulses != 1) begin errs++; $display("FAIL dwr_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_tie();
        bit exp_d;
        do_reset();
        bus.i_addr = 32'h0000_2040; bus.d_addr = 32'h0000_3080;
        bus.i_read = 1; bus.d_read = 1;
        exp_d = pick_d(1, 1); last_d = exp_d;
        tick();
        checks++; if (bus.mem_addr !== (exp_d ? 32'h3080 : 32'h2040)) begin errs++; $display("FAIL tie_first got addr=%h want d=%0b", bus.mem_addr, exp_d); end
        bus.mem_resp = 1; #1;
        checks++; if (bus.d_resp !== exp_d || bus.i_resp !== !exp_d) begin errs++; $display("FAIL tie_first_resp got i=%0b d=%0b", bus.i_resp, bus.d_resp); end
        tick();
        bus.mem_resp = 0;   // D keeps requesting through the bubble
        checks++; if (bus.mem_read !== 1'b0) begin errs++; $display("FAIL tie_bubble got rd=%0b want 0", bus.mem_read); end
        exp_d = pick_d(1, 1); last_d = exp_d;
        tick();
        checks++; if (bus.mem_addr !== (exp_d ? 32'h3080 : 32'h2040)) begin errs++; $display("FAIL tie_second got addr=%h want d=%0b", bus.mem_addr, exp_d); end
        bus.mem_resp = 1; #1;
        checks++; if (bus.d_resp !== exp_d || bus.i_resp !== !exp_d) begin errs++; $display("FAIL tie_second_resp got i=%0b d=%0b", bus.i_resp, bus.d_resp); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_alternating();
        bit exp_d;
        bus.i_addr = 32'h0000_4000; bus.d_addr = 32'h0000_8000;
        bus.i_read = 1; bus.d_read = 1;
        for (int t = 0; t < 6; t++) begin
            exp_d = pick_d(1, 1); last_d = exp_d;
            tick();
            checks++; if (bus.mem_addr !== (exp_d ? 32'h8000 : 32'h4000)) begin errs++; $display("FAIL alt_grant%0d got addr=%h want d=%0b", t, bus.mem_addr, exp_d); end
            repeat ($urandom_range(0, 2)) tick();
            bus.mem_resp = 1; #1;
            checks++; if (bus.d_resp !== exp_d || bus.i_resp !== !exp_d) begin errs++; $display("FAIL alt_resp%0d got i=%0b d=%0b want d=%0b", t, bus.i_resp, bus.d_resp, exp_d); end
            tick();
            bus.mem_resp = 0;
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        bus.d_addr = 32'h0000_5500; bus.d_wdata = rand_line(); bus.d_write = 1;
        tick();
        checks++; if (bus.mem_write !== 1'b1) begin errs++; $display("FAIL rstmid_pre got wr=%0b want 1", bus.mem_write); end
        #2 rst_n = 0; #1;
        checks++; if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0) begin errs++; $display("FAIL rstmid_async got wr=%0b rd=%0b want 0/0", bus.mem_write, bus.mem_read); end
        tick();
        rst_n = 1; bus.d_write = 0; last_d = 0;
        tick();
        bus.mem_resp = 1; #1;
        checks++; if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin errs++; $display("FAIL rstmid_stray got i=%0b d=%0b want 0/0", bus.i_resp, bus.d_resp); end
        tick();
        bus.mem_resp = 0;
        checks++; if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0) begin errs++; $display("FAIL rstmid_idle got wr=%0b rd=%0b want 0/0", bus.mem_write, bus.mem_read); end
    endtask

    task automatic test_rw_both();
        bus.d_addr = 32'h0000_7720; bus.d_read = 1; bus.d_write = 1;
        last_d = 1;
        tick();
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin errs++; $display("FAIL rwboth got wr=%0b rd=%0b want 1/0", bus.mem_write, bus.mem_read); end
        bus.mem_resp = 1; #1;
        checks++; if (bus.d_resp !== 1'b1) begin errs++; $display("FAIL rwboth_resp got %0b want 1", bus.d_resp); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        bit ir, dr, dw, exp_d, exp_wr;
        logic [AW-1:0] ia, da, exp_addr;
        logic [LW-1:0] wd, rd;
        for (int t = 0; t < 25; t++) begin
            ir = 1'($urandom); dr = 1'($urandom); dw = 1'($urandom);
            if (!ir && !dr && !dw) begin
                bus.mem_resp = 1; #1;
                checks++; if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin errs++; $display("FAIL rnd_idle_resp%0d got i=%0b d=%0b", t, bus.i_resp, bus.d_resp); end
                tick();
                bus.mem_resp = 0;
                continue;
            end
            ia = $urandom; da = $urandom; wd = rand_line();
            bus.i_addr = ia; bus.d_addr = da; bus.d_wdata = wd;
            bus.i_read = ir; bus.d_read = dr; bus.d_write = dw;
            exp_d = pick_d(ir, dr | dw); last_d = exp_d;
            exp_wr = exp_d && dw;
            exp_addr = line_of(exp_d ? da : ia);
            tick();
            bus.i_addr = $urandom; bus.d_addr = $urandom; bus.d_wdata = rand_line();
            checks++; if (bus.mem_write !== exp_wr || bus.mem_read !== !exp_wr || bus.mem_addr !== exp_addr) begin errs++; $display("FAIL rnd_grant%0d got wr=%0b rd=%0b addr=%h want %0b/%0b/%h", t, bus.mem_write, bus.mem_read, bus.mem_addr, exp_wr, !exp_wr, exp_addr); end
            repeat ($urandom_range(0, 3)) tick();
            if (exp_wr) begin
                checks++; if (bus.mem_wdata !== wd) begin errs++; $display("FAIL rnd_wdata%0d got %h want %h", t, bus.mem_wdata, wd); end
            end
            checks++; if (bus.mem_addr !== exp_addr) begin errs++; $display("FAIL rnd_hold%0d got %h want %h", t, bus.mem_addr, exp_addr); end
            rd = rand_line();
            bus.mem_rdata = rd; bus.mem_resp = 1; #1;
            checks++; if (bus.d_resp !== exp_d || bus.i_resp !== !exp_d) begin errs++; $display("FAIL rnd_resp%0d got i=%0b d=%0b want d=%0b", t, bus.i_resp, bus.d_resp, exp_d); end
            checks++; if ((exp_d ? bus.d_rdata : bus.i_rdata) !== rd) begin errs++; $display("FAIL rnd_rdata%0d mismatching line data", t); end
            tick();
            clear_inputs();
            checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin errs++; $display("FAIL rnd_done%0d got rd=%0b wr=%0b want 0/0", t, bus.mem_read, bus.mem_write); end
        end
    endtask

    initial begin
        bus.i_addr = '0; bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0;
        clear_inputs();
        last_d = 0;
        test_reset();
        test_i_read();
        test_d_write();
        test_tie();
        test_alternating();
        test_reset_mid();
        test_rw_both();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/cacheline_arbiter.md
# cacheline_arbiter

Arbitrates a single cacheline-wide backing-memory port between the instruction-cache miss path and the data-cache miss/writeback path of the 5-stage RV32I pipeline. The block sits below both caches and above the memory model. It owns the grant state machine and registers the winning request. It returns the response only to the granted side, so the caches' `imem_resp`/`dmem_resp` (and therefore the pipeline `move` and WB-stage `dmem_resp` qualification) are never falsely asserted.

## Interface
Parameters:
- `ADDR_W`, default 32: byte address width.
- `LINE_W`, default 256: cacheline data width.

Ports. Clock and reset come first. Reset is asynchronous and active-low (`rst_n`).
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `i_addr` input ADDR_W: I-side line address; bits [4:0] ignored.
- `i_read` input 1: I-side line read request. The I-side never writes.
- `i_rdata` output LINE_W: line data returned to the I-side.
- `i_resp` output 1: I-side completion, one cycle.
- `d_addr` input ADDR_W: D-side line address.
- `d_read` input 1: D-side line read request.
- `d_write` input 1: D-side line writeback request.
- `d_wdata` input LINE_W: D-side writeback data.
- `d_rdata` output LINE_W: line data returned to the D-side.
- `d_resp` output 1: D-side completion, one cycle.
- `mem_addr` output ADDR_W: registered line address, with [4:0] forced to 0.
- `mem_read` output 1: memory read strobe.
- `mem_write` output 1: memory write strobe.
- `mem_wdata` output LINE_W: registered writeback data.
- `mem_rdata` input LINE_W: memory read data.
- `mem_resp` input 1: memory completion, one cycle.

## Operation
- The FSM has three states: `ARB_IDLE`, `ARB_I`, `ARB_D`.
- In `ARB_IDLE`, the block samples `i_read`, `d_read` and `d_write`.
  - If exactly one side is requesting, that side is granted.
  - If both sides request, the tie rule from Configuration applies.
  - On grant, the address is captured with its low 5 bits zeroed. For a D-side grant, `d_wdata` and the op type are also captured.
- In `ARB_I` or `ARB_D`:
  - `mem_read` or `mem_write` is driven from the captured op and held until `mem_resp`.
  - New requester inputs are ignored.
  - Captured address and data stay stable even if the requester changes its inputs.
- When `mem_resp` is high, the granted side's `*_resp` is asserted in the same cycle and `mem_rdata` is passed through to its `*_rdata`. The FSM then returns to `ARB_IDLE`.
- The non-granted side's `*_resp` is always 0.
- `i_rdata` and `d_rdata` may carry `mem_rdata` continuously. Requesters must qualify the data with `*_resp`.
- If `d_read` and `d_write` are asserted together, the request is treated as a write. This is a requester error.
- A requester deasserting its request while granted is illegal. The arbiter completes the memory transaction anyway and still pulses `*_resp`.
- An `mem_resp` received in `ARB_IDLE` is ignored. No `*_resp` is generated for it.

## Timing
- Reset values:
  - State is `ARB_IDLE`.
  - `mem_read`, `mem_write`, `i_resp`, `d_resp` are 0.
  - `mem_addr` and `mem_wdata` are 0.
  - The round-robin pointer favours D.
- Latency: a request seen in `ARB_IDLE` at cycle N produces a strobe at cycle N+1. Response is combinational with `mem_resp`.
- There is one `ARB_IDLE` bubble between back-to-back grants. Minimum request-to-resp time is 2 cycles when memory responds in 1.
- Requesters hold their request until they sample `*_resp`, and deassert it the following cycle.
- Reset asserted mid-transaction:
  - The FSM returns to `ARB_IDLE` and strobes drop immediately (asynchronous).
  - Any late `mem_resp` after reset is ignored.
- The memory strobes and captured fields are flop outputs. No combinational path runs from requester inputs to `mem_*`.

## Configuration
- Macro: `CACHELINE_ARB_RR_EN`.
- Defined: round-robin arbitration. A 1-bit pointer records the last winner. On a tie, the side that did not last win is granted. The pointer updates on every grant.
- Undefined: fixed priority, with the D-side always winning ties. The I-side can starve under continuous D traffic, which is acceptable for the in-order pipeline because D misses stall fetch anyway.

## Structure
- Shared package `rv32i_types` holds:
  - `arb_state_t`, enum {`ARB_IDLE`, `ARB_I`, `ARB_D`}.
  - `CACHELINE_W` = 256.
  - `LINE_OFFSET_W` = 5.
- There is no sub-module: one FSM plus capture registers in a single module of roughly 150–200 lines.

## Test plan
- I-side only, `i_read` with `i_addr`=0x6000_0044, memory responds after 3 cycles. Expected: `mem_addr`=0x6000_0040 and `mem_read`=1 from cycle 1 to 4; `i_resp`=1 on cycle 4 with `i_rdata`=`mem_rdata`; `d_resp` stays 0.
- D writeback, `d_addr`=0x1F00 with `d_wdata`=0xA5…A5. Expected: `mem_write`=1 and `mem_wdata` equal to the captured value, stable even while `d_wdata` is changed mid-transaction; `d_resp` pulses once.
- Simultaneous `i_read` and `d_read` from reset.
  - With `CACHELINE_ARB_RR_EN`: D is granted first, then I.
  - Without it: D is granted first. If D re-requests in the bubble cycle, D wins again.
- Alternating continuous requests under round-robin: grants go D, I, D, I, and each side receives exactly one `*_resp` per transaction.
- `rst_n` pulled low while in `ARB_D` with `mem_write`=1. Expected: `mem_write`=0 asynchronously, state is `ARB_IDLE`, and a stray `mem_resp` one cycle later produces no `*_resp`.
- `d_read` and `d_write` asserted together. Expected: `mem_write`=1 and `mem_read`=0.
